// File: rtl/vga_csr_resp.sv
// vga_csr_resp: shares one asynchronous SRAM between a fixed-latency video
// read port and a single-entry buffered host write port. A video read takes
// every memory cycle it asks for. A buffered host write uses the next cycle
// that no video read claims.
//
// Handshakes:
//   video : csr_stb_i is a one-cycle request, qualified by enable. There is
//           no back-pressure. csr_dat_o updates exactly 3 cycles after the
//           strobe cycle and then holds.
//   host  : host_stb_i and its operands are held until host_ack_o, which
//           pulses for one cycle. Operands are captured on the first strobe
//           seen in IDLE.
//
// Optional build macro: VGA_CSR_RESP_BYTESEL_EN enables host byte lanes.
// When it is not defined, both lanes are always written and host_sel_i is
// ignored.
module vga_csr_resp (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [17:1] csr_adr_i,
   input  logic        csr_stb_i,
   output logic [15:0] csr_dat_o,
   input  logic [17:1] host_adr_i,
   input  logic [15:0] host_dat_i,
   input  logic [1:0]  host_sel_i,
   input  logic        host_stb_i,
   output logic        host_ack_o,
   output logic [17:1] sram_addr_o,
   output logic [15:0] sram_dat_o,
   input  logic [15:0] sram_dat_i,
   output logic        sram_ce_n_o,
   output logic        sram_oe_n_o,
   output logic        sram_we_n_o,
   output logic [1:0]  sram_bw_n_o
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_WRITE, S_ACK} wr_state_t;

   wr_state_t   state_q, state_d;
   logic        rd_issue;
   logic        rd_mem_q, rd_cap_q;
   logic [15:0] rd_buf_q, csr_dat_q;
   logic [17:1] buf_adr_q, buf_adr_d;
   logic [15:0] buf_dat_q, buf_dat_d;
   logic [17:1] addr_q, addr_d;
   logic [15:0] wdat_q, wdat_d;
   logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic [1:0]  bw_n_q, bw_n_d;
   logic        ack_q, ack_d;
   logic [1:0]  wr_bw_n;

`ifdef VGA_CSR_RESP_BYTESEL_EN
   logic [1:0]  buf_sel_q, buf_sel_d;
   assign wr_bw_n = ~buf_sel_q;
`else
   logic [1:0]  unused_sel;
   assign unused_sel = host_sel_i;
   assign wr_bw_n    = 2'b00;
`endif

   // A video request is accepted only on cycles the pipeline advances.
   assign rd_issue = csr_stb_i & enable;

   // Read pipeline. A memory cycle follows the issue edge. The data is
   // captured at the end of that memory cycle and presented one edge later.
   // In-flight reads ignore enable, so their latency stays fixed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_mem_q  <= 1'b0;
         rd_cap_q  <= 1'b0;
         rd_buf_q  <= 16'h0000;
         csr_dat_q <= 16'h0000;
      end else begin
         rd_mem_q <= rd_issue;
         rd_cap_q <= rd_mem_q;
         if (rd_mem_q) rd_buf_q  <= sram_dat_i;
         if (rd_cap_q) csr_dat_q <= rd_buf_q;
      end
   end

   // Next-state logic for the write FSM and the registered memory strobes.
   // A video read issued at an edge overrides anything else for the
   // following memory cycle. That is why PEND only advances when no read is
   // issued.
   always_comb begin
      state_d   = state_q;
      buf_adr_d = buf_adr_q;
      buf_dat_d = buf_dat_q;
`ifdef VGA_CSR_RESP_BYTESEL_EN
      buf_sel_d = buf_sel_q;
`endif
      addr_d = addr_q;
      wdat_d = wdat_q;
      ce_n_d = 1'b1;
      oe_n_d = 1'b1;
      we_n_d = 1'b1;
      bw_n_d = 2'b11;
      ack_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (host_stb_i) begin
               buf_adr_d = host_adr_i;
               buf_dat_d = host_dat_i;
`ifdef VGA_CSR_RESP_BYTESEL_EN
               buf_sel_d = host_sel_i;
`endif
               state_d = S_PEND;
            end
         end
         S_PEND: begin
            if (!rd_issue) begin
               addr_d  = buf_adr_q;
               wdat_d  = buf_dat_q;
               ce_n_d  = 1'b0;
               we_n_d  = 1'b0;
               bw_n_d  = wr_bw_n;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            ack_d   = 1'b1;
            state_d = S_ACK;
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (rd_issue) begin
         addr_d = csr_adr_i;
         ce_n_d = 1'b0;
         oe_n_d = 1'b0;
         we_n_d = 1'b1;
         bw_n_d = 2'b11;
      end
   end

   // Write FSM state, the write buffer and all registered memory-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         buf_adr_q <= '0;
         buf_dat_q <= '0;
`ifdef VGA_CSR_RESP_BYTESEL_EN
         buf_sel_q <= 2'b00;
`endif
         addr_q <= '0;
         wdat_q <= '0;
         ce_n_q <= 1'b1;
         oe_n_q <= 1'b1;
         we_n_q <= 1'b1;
         bw_n_q <= 2'b11;
         ack_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_adr_q <= buf_adr_d;
         buf_dat_q <= buf_dat_d;
`ifdef VGA_CSR_RESP_BYTESEL_EN
         buf_sel_q <= buf_sel_d;
`endif
         addr_q <= addr_d;
         wdat_q <= wdat_d;
         ce_n_q <= ce_n_d;
         oe_n_q <= oe_n_d;
         we_n_q <= we_n_d;
         bw_n_q <= bw_n_d;
         ack_q  <= ack_d;
      end
   end

   assign csr_dat_o   = csr_dat_q;
   assign host_ack_o  = ack_q;
   assign sram_addr_o = addr_q;
   assign sram_dat_o  = wdat_q;
   assign sram_ce_n_o = ce_n_q;
   assign sram_oe_n_o = oe_n_q;
   assign sram_we_n_o = we_n_q;
   assign sram_bw_n_o = bw_n_q;

endmodule

// File: doc/vga_csr_resp.md
VGA_CSR_RESP -- requirements
Module: vga_csr_resp

Interface
REQ-001 SHALL provide: clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: enable  in  1  video pipeline advance qualifier.
REQ-004 SHALL provide: csr_adr_i  in  17 [17:1]  video read word address.
REQ-005 SHALL provide: csr_stb_i  in  1  video read strobe, one cycle per request.
REQ-006 SHALL provide: csr_dat_o  out  16  video read data.
REQ-007 SHALL provide: host_adr_i  in  17 [17:1], host_dat_i  in  16, host_sel_i  in  2, host_stb_i  in  1  host write request.
REQ-008 SHALL provide: host_ack_o  out  1  host write completion, one-cycle pulse.
REQ-009 SHALL provide: sram_addr_o  out  17 [17:1], sram_dat_o  out  16, sram_dat_i  in  16  memory address and data.
REQ-010 SHALL provide: sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each; sram_bw_n_o  out  2; all active-low, registered.

Function
REQ-011 Video read: edge E0 samples csr_stb_i=1 with enable=1; SHALL drive sram_addr_o=csr_adr_i, ce_n=0, oe_n=0, we_n=1 during the following cycle.
REQ-012 Edge E1 SHALL capture sram_dat_i; edge E2 SHALL load csr_dat_o; data valid from E2, i.e. exactly 3 cycles after the strobe cycle.
REQ-013 csr_dat_o SHALL hold its value until the next video read completes.
REQ-014 With enable=0, csr_stb_i SHALL be ignored; reads in flight SHALL complete at their fixed latency.
REQ-015 Write FSM states: IDLE, PEND, WRITE, ACK.
REQ-016 IDLE: host_stb_i=1 SHALL latch adr, dat, and sel into a one-entry buffer, then go to PEND.
REQ-017 PEND: if no video read is issued at this edge, go to WRITE; otherwise stay in PEND, because video reads have strict priority.
REQ-018 WRITE cycle: sram_addr_o=buffer address, sram_dat_o=buffer data, ce_n=0, we_n=0, oe_n=1, bw_n per REQ-027/028; then go to ACK.
REQ-019 ACK: host_ack_o=1 for exactly one cycle; host_stb_i SHALL be ignored in this cycle; then go to IDLE.
REQ-020 Host SHALL hold host_stb_i and its operands until host_ack_o; operands changing before ack SHALL have no effect after capture.
REQ-021 Video strobes arriving at most every other cycle SHALL never delay a pending write by more than 1 cycle.
REQ-022 Idle memory cycles: ce_n=oe_n=we_n=1, bw_n=2'b11; sram_addr_o holds its last value.
REQ-023 A read capture at E1 and a write issued at E1 SHALL both be honoured without corrupting the read data.

Reset
REQ-024 rst=1 SHALL asynchronously force: csr_dat_o=0, sram_addr_o=0, sram_dat_o=0, ce_n=oe_n=we_n=1, bw_n=2'b11, host_ack_o=0, FSM=IDLE.
REQ-025 Reset mid-operation SHALL discard the buffered write and any reads in flight, with no ack and no memory write.
REQ-026 The first strobe sampled after rst deasserts SHALL be served normally.

Configuration
REQ-027 VGA_CSR_RESP_BYTESEL_EN defined: in WRITE, sram_bw_n_o SHALL equal ~host_sel_i as latched; a latched sel of 2'b00 SHALL complete with ack and no lanes enabled.
REQ-028 VGA_CSR_RESP_BYTESEL_EN undefined: host_sel_i SHALL be ignored and sram_bw_n_o=2'b00 in WRITE; the port list is unchanged.

Verification
REQ-029 Reset release, then csr_stb_i at cycle 0 with adr=17'h00123 and memory returning 16'hBEEF -> sram_addr_o=0x00123, oe_n=0 in cycle 1; csr_dat_o=16'hBEEF from cycle 3.
REQ-030 Host write adr=17'h00040, dat=16'h5A5A, no video traffic -> WRITE at cycle 2 with we_n=0; host_ack_o high only at cycle 3.
REQ-031 Video strobes on every even cycle plus a host write -> all reads return data at +3 cycles; the write completes with ack within 4 cycles of strobe.
REQ-032 BYTESEL_EN defined, sel=2'b01 -> bw_n=2'b10 in WRITE; undefined -> bw_n=2'b00.
REQ-033 rst asserted during PEND -> no we_n pulse, no ack, outputs at reset values immediately; next write completes normally.
REQ-034 enable=0 with csr_stb_i=1 -> oe_n stays 1 and csr_dat_o unchanged.
